mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline MEM stage between the execute stage and WriteBack.
- Accepts one instruction at a time from EX over a valid/ready handshake and performs the load/store against data memory through a req/resp handshake with variable latency.
- Registers pc, mem_out, alu_out, mem_rf_dest and opcode for WriteBack.
- Back-pressures EX while a memory access is outstanding.

Parameters:
- TIMEOUT, 255: maximum cycles spent in WAIT before a load is aborted.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  EX presents an instruction.
- in_ready  out  1  stage can accept; high only in IDLE.
- pc_in  in  32  instruction PC.
- alu_in  in  32  ALU result / effective address.
- store_data  in  32  rt value for stores.
- rf_dest_in  in  5  destination register.
- opcode_in  in  6  MIPS opcode.
- dmem_req_valid  out  1  memory request valid.
- dmem_req_ready  in  1  memory accepts request.
- dmem_addr  out  32  word address {alu_in[31:2],2'b00}.
- dmem_we  out  1  1 = store.
- dmem_wdata  out  32  store data.
- dmem_wstrb  out  4  byte enables.
- dmem_resp_valid  in  1  load data valid.
- dmem_rdata  in  32  load data word.
- pc  out  32  registered to WriteBack.
- mem_out  out  32  registered load result.
- alu_out  out  32  registered ALU result.
- mem_rf_dest  out  5  registered destination.
- opcode  out  6  registered opcode.
- out_valid  out  1  one-cycle pulse per retired instruction.
- mem_err  out  1  one-cycle pulse: misaligned access or load timeout.

Behaviour:
- Memory opcodes are lw 0x23, lb 0x20, lbu 0x24, sw 0x2B and sb 0x28. All other opcodes pass through.
- States are IDLE, REQ, WAIT and OUT.
- All transactions are captured into internal registers on accept (in_valid & in_ready).
- Reset values:
  - state = IDLE; out_valid = 0; mem_err = 0; dmem_req_valid = 0.
  - pc, mem_out, alu_out = 0; mem_rf_dest = 0; opcode = 6'd2; counter = 0.
- Bubble encoding: whenever out_valid = 0, opcode = 6'd2 and mem_rf_dest = 0. This guarantees WriteBack does not write the register file.
- IDLE:
  - On accept of a non-memory op, go to OUT. Outputs appear the next cycle, so latency is 1.
  - On accept of a memory op, go to REQ.
  - Misaligned access (lw/sw with alu_in[1:0] != 0) goes directly to OUT with no dmem request. It retires with opcode 6'd2, mem_rf_dest 0 and mem_err = 1.
- REQ:
  - dmem_req_valid = 1 with stable addr, we, wdata and wstrb until dmem_req_ready.
  - Store: on handshake go to OUT. Stores are posted.
  - Load: on handshake go to WAIT and clear the counter.
- WAIT:
  - On dmem_resp_valid, latch the extracted data and go to OUT.
  - The counter increments each cycle. At count == TIMEOUT, go to OUT with the load squashed (opcode 6'd2, mem_err = 1).
  - dmem_resp_valid outside WAIT is ignored.
- OUT:
  - out_valid = 1 for exactly one cycle, then return to IDLE.
  - in_ready = 0 in OUT. Maximum throughput is one instruction per 2 cycles.
- Store encoding:
  - sw: wstrb = 4'b1111, wdata = store_data.
  - sb: wstrb = 4'b0001 << alu_in[1:0], wdata = store_data[7:0] replicated 4 times.
- Load extract is little-endian: the byte is selected by addr[1:0].
  - lb sign-extends; lbu zero-extends; lw returns the full word.
- alu_out is always forwarded unchanged. mem_out = 0 for non-loads.
- A reset mid-transaction abandons the transaction:
  - dmem_req_valid is low the cycle after reset is asserted.
  - No retirement occurs.
  - A late response after reset is ignored.
- in_ready is combinational from state only. It does not depend on in_valid.

Test Plan:
- Non-memory op: opcode 0x00, alu_in 0x1234, rf_dest 5 → next cycle out_valid = 1, alu_out 0x1234, mem_rf_dest 5, opcode 0x00. Following cycle shows the bubble (opcode 2).
- lw at 0x100, dmem_req_ready delayed 3 cycles, response 0xDEADBEEF after 2 more cycles → req held stable; one out_valid pulse with mem_out 0xDEADBEEF; in_ready low throughout.
- lb at 0x103, rdata 0x80FF7F01 → mem_out 0xFFFFFF80. lbu at the same address → mem_out 0x00000080.
- sb at 0x102, store_data 0x000000AB → wstrb 4'b0100, wdata 0xABABABAB, dmem_addr 0x100. Retires the cycle after the handshake, opcode 0x28.
- lw at 0x101 → no dmem_req_valid; out_valid = 1 with mem_err = 1 and opcode 2. lw with no response for 255 cycles → mem_err = 1, opcode 2.
- rst asserted while in WAIT, then dmem_resp_valid pulses → no out_valid; state IDLE; in_ready = 1; outputs at reset values.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Signal bundle for the MEM stage: EX handshake, data-memory request/response port
// and the registered WriteBack outputs. The stage uses 'slave'; its environment uses 'master'.
interface mem_access_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc_in;
    logic [31:0] alu_in;
    logic [31:0] store_data;
    logic [4:0]  rf_dest_in;
    logic [5:0]  opcode_in;

    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_resp_valid;
    logic [31:0] dmem_rdata;

    logic [31:0] pc;
    logic [31:0] mem_out;
    logic [31:0] alu_out;
    logic [4:0]  mem_rf_dest;
    logic [5:0]  opcode;
    logic        out_valid;
    logic        mem_err;

    modport slave (
        input  in_valid, pc_in, alu_in, store_data, rf_dest_in, opcode_in,
        input  dmem_req_ready, dmem_resp_valid, dmem_rdata,
        output in_ready,
        output dmem_req_valid, dmem_addr, dmem_we, dmem_wdata, dmem_wstrb,
        output pc, mem_out, alu_out, mem_rf_dest, opcode, out_valid, mem_err
    );

    modport master (
        output in_valid, pc_in, alu_in, store_data, rf_dest_in, opcode_in,
        output dmem_req_ready, dmem_resp_valid, dmem_rdata,
        input  in_ready,
        input  dmem_req_valid, dmem_addr, dmem_we, dmem_wdata, dmem_wstrb,
        input  pc, mem_out, alu_out, mem_rf_dest, opcode, out_valid, mem_err
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: one instruction in flight, load/store against a variable-latency
// data memory, registered results to WriteBack with a fixed bubble encoding when idle.
module mem_access_stage #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_stage_if.slave  bus
);

    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_BUBBLE = 6'd2;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] mem_out;
        logic [31:0] alu_out;
        logic [4:0]  rf_dest;
        logic [5:0]  opcode;
        logic        err;
    } ret_t;

    state_t      r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt;

    // Transaction captured on accept
    logic [31:0] r_pc, r_alu, r_addr, r_wdata;
    logic [4:0]  r_rf_dest;
    logic [5:0]  r_opcode;
    logic        r_we;
    logic [3:0]  r_wstrb;

    ret_t        r_ret, w_ret;
    logic        r_out_valid, w_ret_load;

    logic        w_in_ready, w_accept;
    logic        w_is_load_in, w_is_store_in, w_misaligned_in;
    logic [7:0]  w_byte;
    logic [31:0] w_load_data;

    assign w_in_ready      = (r_state == S_IDLE);
    assign w_accept        = bus.in_valid & w_in_ready;
    assign w_is_load_in    = (bus.opcode_in == OP_LW) || (bus.opcode_in == OP_LB) ||
                             (bus.opcode_in == OP_LBU);
    assign w_is_store_in   = (bus.opcode_in == OP_SW) || (bus.opcode_in == OP_SB);
    assign w_misaligned_in = ((bus.opcode_in == OP_LW) || (bus.opcode_in == OP_SW)) &&
                             (bus.alu_in[1:0] != 2'b00);

    always_comb begin
        w_byte = bus.dmem_rdata[7:0];
        case (r_alu[1:0])
            2'd1:    w_byte = bus.dmem_rdata[15:8];
            2'd2:    w_byte = bus.dmem_rdata[23:16];
            2'd3:    w_byte = bus.dmem_rdata[31:24];
            default: w_byte = bus.dmem_rdata[7:0];
        endcase
    end

    always_comb begin
        case (r_opcode)
            OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_data = {24'd0, w_byte};
            default: w_load_data = bus.dmem_rdata;
        endcase
    end

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        w_next_state   = r_state;
        w_ret_load     = 1'b0;
        w_ret.pc       = r_pc;
        w_ret.mem_out  = 32'd0;
        w_ret.alu_out  = r_alu;
        w_ret.rf_dest  = r_rf_dest;
        w_ret.opcode   = r_opcode;
        w_ret.err      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_ret.pc      = bus.pc_in;
                    w_ret.alu_out = bus.alu_in;
                    w_ret.rf_dest = bus.rf_dest_in;
                    w_ret.opcode  = bus.opcode_in;
                    if (w_misaligned_in) begin
                        w_next_state  = S_OUT;
                        w_ret_load    = 1'b1;
                        w_ret.rf_dest = 5'd0;
                        w_ret.opcode  = OP_BUBBLE;
                        w_ret.err     = 1'b1;
                    end else if (w_is_load_in || w_is_store_in) begin
                        w_next_state = S_REQ;
                    end else begin
                        w_next_state = S_OUT;
                        w_ret_load   = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (bus.dmem_req_ready) begin
                    if (r_we) begin
                        w_next_state = S_OUT;
                        w_ret_load   = 1'b1;
                    end else begin
                        w_next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A response arriving on the timeout cycle still wins
                if (bus.dmem_resp_valid) begin
                    w_next_state  = S_OUT;
                    w_ret_load    = 1'b1;
                    w_ret.mem_out = w_load_data;
                end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                    w_next_state  = S_OUT;
                    w_ret_load    = 1'b1;
                    w_ret.rf_dest = 5'd0;
                    w_ret.opcode  = OP_BUBBLE;
                    w_ret.err     = 1'b1;
                end
            end
            S_OUT:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pc        <= 32'd0;
            r_alu       <= 32'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_rf_dest   <= 5'd0;
            r_opcode    <= OP_BUBBLE;
            r_we        <= 1'b0;
            r_wstrb     <= 4'd0;
            r_out_valid <= 1'b0;
            r_ret       <= '{pc: 32'd0, mem_out: 32'd0, alu_out: 32'd0,
                             rf_dest: 5'd0, opcode: OP_BUBBLE, err: 1'b0};
        end else begin
            r_state <= w_next_state;

            if (w_accept) begin
                r_pc      <= bus.pc_in;
                r_alu     <= bus.alu_in;
                r_rf_dest <= bus.rf_dest_in;
                r_opcode  <= bus.opcode_in;
                r_addr    <= {bus.alu_in[31:2], 2'b00};
                r_we      <= w_is_store_in;
                if (bus.opcode_in == OP_SB) begin
                    r_wdata <= {4{bus.store_data[7:0]}};
                    r_wstrb <= 4'b0001 << bus.alu_in[1:0];
                end else begin
                    r_wdata <= bus.store_data;
                    r_wstrb <= (bus.opcode_in == OP_SW) ? 4'b1111 : 4'b0000;
                end
            end

            if (r_state == S_REQ && bus.dmem_req_ready) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_ret_load) begin
                r_ret       <= w_ret;
                r_out_valid <= 1'b1;
            end else if (r_out_valid) begin
                r_out_valid   <= 1'b0;
                r_ret.rf_dest <= 5'd0;
                r_ret.opcode  <= OP_BUBBLE;
                r_ret.err     <= 1'b0;
            end
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.dmem_req_valid = (r_state == S_REQ);
    assign bus.dmem_addr      = r_addr;
    assign bus.dmem_we        = r_we;
    assign bus.dmem_wdata     = r_wdata;
    assign bus.dmem_wstrb     = r_wstrb;

    assign bus.pc          = r_ret.pc;
    assign bus.mem_out     = r_ret.mem_out;
    assign bus.alu_out     = r_ret.alu_out;
    assign bus.mem_rf_dest = r_ret.rf_dest;
    assign bus.opcode      = r_ret.opcode;
    assign bus.mem_err     = r_ret.err;
    assign bus.out_valid   = r_out_valid;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: stimulus pushes hand-computed retirements into a
// scoreboard queue; a negedge monitor pops and compares whenever out_valid is seen.
module tb_mem_access_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] mem_out;
        logic [31:0] alu_out;
        logic [4:0]  dest;
        logic [5:0]  op;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    mem_access_stage_if bus ();

    mem_access_stage #(.TIMEOUT(255), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_cmp  = 0;
    int   n_err  = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];
    exp_t mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, mem, alu, input logic [4:0] dest,
                            input logic [5:0] op, input logic err);
        exp_t e;
        e.pc = pc; e.mem_out = mem; e.alu_out = alu; e.dest = dest; e.op = op; e.err = err;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_retire: out_valid=1 pc=%h, expected no retirement", bus.pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ret_pc",      bus.pc,          mon_e.pc);
                    check("ret_mem_out", bus.mem_out,     mon_e.mem_out);
                    check("ret_alu_out", bus.alu_out,     mon_e.alu_out);
                    check("ret_dest",    bus.mem_rf_dest, 32'(mon_e.dest));
                    check("ret_opcode",  bus.opcode,      32'(mon_e.op));
                    check("ret_mem_err", bus.mem_err,     32'(mon_e.err));
                end
            end else begin
                check("bubble_opcode", bus.opcode,      32'd2);
                check("bubble_dest",   bus.mem_rf_dest, 32'd0);
                check("bubble_err",    bus.mem_err,     32'd0);
            end
        end
    end

    // All tasks start and end at posedge+1.
    task automatic issue(input logic [5:0] op, input logic [31:0] pc, alu, sd,
                         input logic [4:0] dest);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("issue_in_ready", bus.in_ready, 32'd1);
        bus.opcode_in  = op;
        bus.pc_in      = pc;
        bus.alu_in     = alu;
        bus.store_data = sd;
        bus.rf_dest_in = dest;
        bus.in_valid   = 1'b1;
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d retirements pending, expected 0", exp_q.size());
        end
        #1;
    endtask

    task automatic run_load(input logic [5:0] op, input logic [31:0] pc, alu,
                            input logic [4:0] dest, input int req_dly, resp_dly,
                            input logic [31:0] rdata, exp_addr);
        issue(op, pc, alu, 32'd0, dest);
        repeat (req_dly) begin
            @(negedge clk);
            check("ld_req_valid", bus.dmem_req_valid, 32'd1);
            check("ld_req_addr",  bus.dmem_addr,      exp_addr);
            check("ld_req_we",    bus.dmem_we,        32'd0);
            check("ld_in_ready",  bus.in_ready,       32'd0);
            @(posedge clk); #1;
        end
        bus.dmem_req_ready = 1'b1;
        @(negedge clk);
        check("ld_hs_valid", bus.dmem_req_valid, 32'd1);
        check("ld_hs_addr",  bus.dmem_addr,      exp_addr);
        @(posedge clk); #1;
        bus.dmem_req_ready = 1'b0;
        repeat (resp_dly) begin
            @(negedge clk);
            check("wait_req_valid", bus.dmem_req_valid, 32'd0);
            check("wait_in_ready",  bus.in_ready,       32'd0);
            @(posedge clk); #1;
        end
        bus.dmem_rdata      = rdata;
        bus.dmem_resp_valid = 1'b1;
        @(posedge clk); #1;
        bus.dmem_resp_valid = 1'b0;
        wait_drain();
    endtask

    task automatic run_store(input logic [5:0] op, input logic [31:0] pc, alu, sd,
                             input logic [31:0] exp_addr, exp_wdata, input logic [3:0] exp_wstrb);
        issue(op, pc, alu, sd, 5'd0);
        @(negedge clk);
        check("st_req_valid", bus.dmem_req_valid, 32'd1);
        check("st_addr",      bus.dmem_addr,      exp_addr);
        check("st_we",        bus.dmem_we,        32'd1);
        check("st_wdata",     bus.dmem_wdata,     exp_wdata);
        check("st_wstrb",     bus.dmem_wstrb,     32'(exp_wstrb));
        @(posedge clk); #1;
        bus.dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.dmem_req_ready = 1'b0;
        @(negedge clk);
        check("st_posted_retire", bus.out_valid, 32'd1);
        @(posedge clk); #1;
        wait_drain();
    endtask

    initial begin
        int n;
        bus.in_valid        = 1'b0;
        bus.pc_in           = 32'd0;
        bus.alu_in          = 32'd0;
        bus.store_data      = 32'd0;
        bus.rf_dest_in      = 5'd0;
        bus.opcode_in       = 6'd0;
        bus.dmem_req_ready  = 1'b0;
        bus.dmem_resp_valid = 1'b0;
        bus.dmem_rdata      = 32'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid,      32'd0);
        check("rst_mem_err",   bus.mem_err,        32'd0);
        check("rst_req_valid", bus.dmem_req_valid, 32'd0);
        check("rst_opcode",    bus.opcode,         32'd2);
        check("rst_dest",      bus.mem_rf_dest,    32'd0);
        check("rst_pc",        bus.pc,             32'd0);
        check("rst_alu_out",   bus.alu_out,        32'd0);
        check("rst_mem_out",   bus.mem_out,        32'd0);
        check("rst_in_ready",  bus.in_ready,       32'd1);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Non-memory op: one-cycle latency, bubble on the following cycle
        push_exp(32'h40, 32'd0, 32'h1234, 5'd5, 6'h00, 1'b0);
        issue(6'h00, 32'h40, 32'h1234, 32'd0, 5'd5);
        @(negedge clk);
        check("nonmem_latency", bus.out_valid, 32'd1);
        @(negedge clk);
        check("nonmem_bubble_op", bus.opcode, 32'd2);
        @(posedge clk); #1;

        // Back-to-back pass-through ops
        push_exp(32'h44, 32'd0, 32'hABCD0000, 5'd7, 6'h0F, 1'b0);
        push_exp(32'h48, 32'd0, 32'h00000009, 5'd8, 6'h08, 1'b0);
        issue(6'h0F, 32'h44, 32'hABCD0000, 32'd0, 5'd7);
        issue(6'h08, 32'h48, 32'h00000009, 32'd0, 5'd8);
        wait_drain();

        // Loads
        push_exp(32'h50, 32'hDEADBEEF, 32'h100, 5'd9, 6'h23, 1'b0);
        run_load(6'h23, 32'h50, 32'h100, 5'd9, 3, 2, 32'hDEADBEEF, 32'h100);
        push_exp(32'h54, 32'hFFFFFF80, 32'h103, 5'd10, 6'h20, 1'b0);
        run_load(6'h20, 32'h54, 32'h103, 5'd10, 0, 1, 32'h80FF7F01, 32'h100);
        push_exp(32'h58, 32'h00000080, 32'h103, 5'd11, 6'h24, 1'b0);
        run_load(6'h24, 32'h58, 32'h103, 5'd11, 0, 1, 32'h80FF7F01, 32'h100);
        push_exp(32'h5C, 32'h0000007F, 32'h101, 5'd12, 6'h20, 1'b0);
        run_load(6'h20, 32'h5C, 32'h101, 5'd12, 1, 0, 32'h80FF7F01, 32'h100);
        push_exp(32'h60, 32'hFFFFFFFF, 32'h102, 5'd13, 6'h20, 1'b0);
        run_load(6'h20, 32'h60, 32'h102, 5'd13, 0, 0, 32'h80FF7F01, 32'h100);

        // Stores
        push_exp(32'h64, 32'd0, 32'h102, 5'd0, 6'h28, 1'b0);
        run_store(6'h28, 32'h64, 32'h102, 32'h000000AB, 32'h100, 32'hABABABAB, 4'b0100);
        push_exp(32'h68, 32'd0, 32'h200, 5'd0, 6'h2B, 1'b0);
        run_store(6'h2B, 32'h68, 32'h200, 32'hCAFEF00D, 32'h200, 32'hCAFEF00D, 4'b1111);

        // Misaligned word accesses retire immediately with an error and no request
        push_exp(32'h6C, 32'd0, 32'h101, 5'd0, 6'd2, 1'b1);
        issue(6'h23, 32'h6C, 32'h101, 32'd0, 5'd6);
        @(negedge clk);
        check("misal_lw_no_req", bus.dmem_req_valid, 32'd0);
        @(posedge clk); #1;
        wait_drain();
        push_exp(32'h70, 32'd0, 32'h102, 5'd0, 6'd2, 1'b1);
        issue(6'h2B, 32'h70, 32'h102, 32'h11223344, 5'd0);
        @(negedge clk);
        check("misal_sw_no_req", bus.dmem_req_valid, 32'd0);
        @(posedge clk); #1;
        wait_drain();

        // Load timeout: WAIT counts 0..255, abort on the edge where the count reads 255
        push_exp(32'h74, 32'd0, 32'h300, 5'd0, 6'd2, 1'b1);
        issue(6'h23, 32'h74, 32'h300, 32'd0, 5'd4);
        bus.dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.dmem_req_ready = 1'b0;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (bus.out_valid === 1'b1) break;
        end
        check("timeout_cycles", n, 32'd257);
        @(posedge clk); #1;
        wait_drain();

        // Reset while waiting for a response, then a late response
        issue(6'h23, 32'h78, 32'h400, 32'd0, 5'd3);
        bus.dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.dmem_req_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.dmem_rdata      = 32'h55AA55AA;
        bus.dmem_resp_valid = 1'b1;
        @(posedge clk); #1;
        bus.dmem_resp_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rstw_in_ready",  bus.in_ready,  32'd1);
        check("rstw_out_valid", bus.out_valid, 32'd0);
        check("rstw_pc",        bus.pc,        32'd0);
        check("rstw_alu_out",   bus.alu_out,   32'd0);
        check("rstw_mem_out",   bus.mem_out,   32'd0);
        check("rstw_opcode",    bus.opcode,    32'd2);

        // Reset while a request is pending drops it on the next cycle
        issue(6'h23, 32'h7C, 32'h500, 32'd0, 5'd2);
        @(negedge clk);
        check("rstr_req_before", bus.dmem_req_valid, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstr_req_after", bus.dmem_req_valid, 32'd0);
        @(posedge clk); #1;
        bus.dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.dmem_req_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rstr_in_ready", bus.in_ready, 32'd1);

        check("leftover_expected", exp_q.size(), 32'd0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
